logic_gate_pipe: RTL and testbench

//  Parametrised, pipelined multi-input logic unit; successor to the fixed 2-input single-bit gates.

---
 rtl/logic_gate_pkg.sv | 46 ++++
 rtl/logic_gate_stage.sv | 45 ++++
 rtl/logic_gate_pipe.sv | 96 +++++++++
 tb/tb_logic_gate_pipe.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/logic_gate_pkg.sv
// rtl/logic_gate_pkg.sv - operator codes and per-bit channel reduction for logic_gate_pipe
package logic_gate_pkg;

    typedef logic [2:0] op_t;

    localparam op_t OP_AND  = 3'd0;
    localparam op_t OP_OR   = 3'd1;
    localparam op_t OP_XOR  = 3'd2;
    localparam op_t OP_NAND = 3'd3;
    localparam op_t OP_NOR  = 3'd4;
    localparam op_t OP_XNOR = 3'd5;
    localparam op_t OP_PASS = 3'd6;
    localparam op_t OP_RSVD = 3'd7;

    localparam int MAX_NCH = 32;

    // Combines one bit position across the first nch channels; bits[0] is channel 0.
    function automatic logic op_bit(input op_t op, input logic [MAX_NCH-1:0] bits, input int nch);
        logic a;
        logic o;
        logic x;
        logic r;
        a = 1'b1;
        o = 1'b0;
        x = 1'b0;
        for (int i = 0; i < MAX_NCH; i++) begin
            if (i < nch) begin
                a = a & bits[i];
                o = o | bits[i];
                x = x ^ bits[i];
            end
        end
        case (op)
            OP_AND:  r = a;
            OP_OR:   r = o;
            OP_XOR:  r = x;
            OP_NAND: r = ~a;
            OP_NOR:  r = ~o;
            OP_XNOR: r = ~x;
            OP_PASS: r = bits[0];
            default: r = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/logic_gate_stage.sv
// rtl/logic_gate_stage.sv - one valid/ready register slice; empty slots hold zero data
module logic_gate_stage #(
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          up_valid,
    output logic          up_ready,
    input  logic [DW-1:0] up_data,
    output logic          dn_valid,
    input  logic          dn_ready,
    output logic [DW-1:0] dn_data
);

    logic          valid_q;
    logic          valid_d;
    logic [DW-1:0] data_q;
    logic [DW-1:0] data_d;
    logic          adv;

    always_comb begin
        adv     = !valid_q || dn_ready;
        valid_d = valid_q;
        data_d  = data_q;
        if (adv) begin
            valid_d = up_valid;
            data_d  = up_valid ? up_data : '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign up_ready = adv;
    assign dn_valid = valid_q;
    assign dn_data  = data_q;

endmodule

// File: rtl/logic_gate_pipe.sv
// rtl/logic_gate_pipe.sv - two-stage multi-channel logic unit with flags and transfer counter
module logic_gate_pipe
    import logic_gate_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int NCH   = 2,
    parameter int CNTW  = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  op_t                  in_op,
    input  logic [NCH*WIDTH-1:0] in_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WIDTH-1:0]     out_data,
    output logic                 out_any,
    output logic                 out_all,
    output logic                 out_err,
    output logic [CNTW-1:0]      xfer_count
);

    localparam int S1W = 3 + NCH * WIDTH;
    localparam int S2W = 3 + WIDTH;

    logic [S1W-1:0]       s1_out;
    logic                 s1_valid;
    logic                 s1_ready;
    op_t                  s1_op;
    logic [NCH*WIDTH-1:0] s1_chan;

    logic [WIDTH-1:0]     res;
    logic [MAX_NCH-1:0]   ch_bits;
    logic [S2W-1:0]       s2_out;

    logic [CNTW-1:0]      xfer_count_q;
    logic [CNTW-1:0]      xfer_count_d;

    logic_gate_stage #(.DW(S1W)) u_s1 (
        .clk      (clk),
        .rst      (rst),
        .up_valid (in_valid),
        .up_ready (in_ready),
        .up_data  ({in_op, in_data}),
        .dn_valid (s1_valid),
        .dn_ready (s1_ready),
        .dn_data  (s1_out)
    );

    assign {s1_op, s1_chan} = s1_out;

    // Gather bit b of every channel, then reduce it with the selected operator.
    always_comb begin
        res     = '0;
        ch_bits = '0;
        for (int b = 0; b < WIDTH; b++) begin
            ch_bits = '0;
            for (int k = 0; k < NCH; k++) begin
                ch_bits[k] = s1_chan[k*WIDTH + b];
            end
            res[b] = op_bit(s1_op, ch_bits, NCH);
        end
    end

    logic_gate_stage #(.DW(S2W)) u_s2 (
        .clk      (clk),
        .rst      (rst),
        .up_valid (s1_valid),
        .up_ready (s1_ready),
        .up_data  ({s1_op == OP_RSVD, &res, |res, res}),
        .dn_valid (out_valid),
        .dn_ready (out_ready),
        .dn_data  (s2_out)
    );

    assign {out_err, out_all, out_any, out_data} = s2_out;

    always_comb begin
        xfer_count_d = xfer_count_q;
        if (out_valid && out_ready && (xfer_count_q != {CNTW{1'b1}})) begin
            xfer_count_d = xfer_count_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            xfer_count_q <= '0;
        end else begin
            xfer_count_q <= xfer_count_d;
        end
    end

    assign xfer_count = xfer_count_q;

endmodule

// File: tb/tb_logic_gate_pipe.sv
// tb/tb_logic_gate_pipe.sv - randomized and directed self-checking bench for logic_gate_pipe
module tb_logic_gate_pipe;
    import logic_gate_pkg::*;

    localparam int W    = 8;
    localparam int NCH  = 2;
    localparam int CNTW = 16;
    localparam int DW   = NCH * W;
    localparam int BN   = 3;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            in_valid = 1'b0;
    logic            in_ready;
    op_t             in_op = 3'd0;
    logic [DW-1:0]   in_data = '0;
    logic            out_valid;
    logic            out_ready = 1'b0;
    logic [W-1:0]    out_data;
    logic            out_any, out_all, out_err;
    logic [CNTW-1:0] xfer_count;

    logic            b_rst = 1'b1;
    logic            b_in_valid = 1'b0;
    logic            b_in_ready;
    op_t             b_op = 3'd0;
    logic [BN*W-1:0] b_data = '0;
    logic            b_out_valid;
    logic            b_out_ready = 1'b1;
    logic [W-1:0]    b_out;
    logic            b_any, b_all, b_err;
    logic [1:0]      b_count;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    logic_gate_pipe #(.WIDTH(W), .NCH(NCH), .CNTW(CNTW)) u_dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
        .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_any(out_any), .out_all(out_all), .out_err(out_err), .xfer_count(xfer_count)
    );

    logic_gate_pipe #(.WIDTH(W), .NCH(BN), .CNTW(2)) u_dut_b (
        .clk(clk), .rst(b_rst), .in_valid(b_in_valid), .in_ready(b_in_ready), .in_op(b_op),
        .in_data(b_data), .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out),
        .out_any(b_any), .out_all(b_all), .out_err(b_err), .xfer_count(b_count)
    );

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Word-level reference: fold whole channels together.
    function automatic logic [W-1:0] model_res(input logic [2:0] op, input logic [DW-1:0] d);
        logic [W-1:0] a, o, x;
        a = '1; o = '0; x = '0;
        for (int k = 0; k < NCH; k++) begin
            a = a & d[k*W +: W];
            o = o | d[k*W +: W];
            x = x ^ d[k*W +: W];
        end
        case (op)
            3'd0: return a;
            3'd1: return o;
            3'd2: return x;
            3'd3: return ~a;
            3'd4: return ~o;
            3'd5: return ~x;
            3'd6: return d[W-1:0];
            default: return '0;
        endcase
    endfunction

    typedef struct {
        logic [2:0]    op;
        logic [DW-1:0] d;
        int            acc;
    } item_t;

    item_t           q[$];
    int              cyc = 0;
    logic [CNTW-1:0] mcount = '0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        logic ev, er;
        logic [W-1:0] r;
        if (rst) begin
            q.delete();
            mcount = '0;
        end else begin
            ev = (q.size() > 0) && (cyc >= q[0].acc + 2);
            er = !(q.size() == 2 && !out_ready);
            check("out_valid", 32'(out_valid), 32'(ev));
            if (ev) begin
                r = model_res(q[0].op, q[0].d);
                check("out_data", 32'(out_data), 32'(r));
                check("out_any", 32'(out_any), 32'(|r));
                check("out_all", 32'(out_all), 32'(&r));
                check("out_err", 32'(out_err), 32'(q[0].op == 3'd7));
            end else begin
                check("idle outputs", 32'({out_data, out_any, out_all, out_err}), 32'd0);
            end
            check("in_ready", 32'(in_ready), 32'(er));
            check("xfer_count", 32'(xfer_count), 32'(mcount));
            if (ev && out_ready) begin
                void'(q.pop_front());
                if (mcount != '1) mcount = mcount + 1'b1;
            end
            if (in_valid && er) q.push_back('{in_op, in_data, cyc});
        end
    end

    task automatic send_lit(input string name, input logic [2:0] op, input logic [DW-1:0] d,
                            input logic [W-1:0] ed, input logic ea, input logic el, input logic ee);
        @(posedge clk); #1;
        in_valid = 1'b1; in_op = op; in_data = d; out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check({name, " valid"}, 32'(out_valid), 32'd1);
        check({name, " data"}, 32'(out_data), 32'(ed));
        check({name, " any"}, 32'(out_any), 32'(ea));
        check({name, " all"}, 32'(out_all), 32'(el));
        check({name, " err"}, 32'(out_err), 32'(ee));
    endtask

    task automatic pulse_rst();
        @(posedge clk); #1;
        rst = 1'b1; in_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    initial begin
        int   i;
        logic saw;
        logic took;

        repeat (2) @(posedge clk);
        #1 rst = 1'b0; b_rst = 1'b0;
        @(negedge clk);
        check("reset out_valid", 32'(out_valid), 32'd0);
        check("reset in_ready", 32'(in_ready), 32'd1);
        check("reset xfer_count", 32'(xfer_count), 32'd0);
        check("reset out_data", 32'(out_data), 32'd0);

        check("model OR", 32'(model_res(3'd1, 16'h3CF0)), 32'hFC);
        check("model XNOR", 32'(model_res(3'd5, 16'hAACC)), 32'h99);

        send_lit("or F0|3C", 3'd1, 16'h3CF0, 8'hFC, 1'b1, 1'b0, 1'b0);
        // Bits 0..3 of CC/AA cover input pairs 00, 01, 10, 11.
        send_lit("tt and",  3'd0, 16'hAACC, 8'h88, 1'b1, 1'b0, 1'b0);
        send_lit("tt or",   3'd1, 16'hAACC, 8'hEE, 1'b1, 1'b0, 1'b0);
        send_lit("tt xor",  3'd2, 16'hAACC, 8'h66, 1'b1, 1'b0, 1'b0);
        send_lit("tt nand", 3'd3, 16'hAACC, 8'h77, 1'b1, 1'b0, 1'b0);
        send_lit("tt nor",  3'd4, 16'hAACC, 8'h11, 1'b1, 1'b0, 1'b0);
        send_lit("tt xnor", 3'd5, 16'hAACC, 8'h99, 1'b1, 1'b0, 1'b0);
        send_lit("rsvd",    3'd7, 16'h5A3C, 8'h00, 1'b0, 1'b0, 1'b1);
        send_lit("pass",    3'd6, 16'h77A5, 8'hA5, 1'b1, 1'b0, 1'b0);
        send_lit("and ones", 3'd0, 16'hFFFF, 8'hFF, 1'b1, 1'b1, 1'b0);

        pulse_rst();
        i = 0; saw = 1'b0;
        for (int c = 0; c < 40 && i < 4; c++) begin
            @(posedge clk); #1;
            out_ready = !(c >= 2 && c < 5);
            in_valid  = 1'b1;
            in_op     = 3'd1;
            in_data   = {8'h00, 8'(8'h11 * (i + 1))};
            #1;
            if (!in_ready) saw = 1'b1;
            if (in_ready) i++;
        end
        @(posedge clk); #1;
        in_valid = 1'b0; out_ready = 1'b1;
        repeat (4) @(posedge clk);
        @(negedge clk);
        check("stall accepted", 32'(i), 32'd4);
        check("stall backpressure", 32'(saw), 32'd1);
        check("stall xfer_count", 32'(xfer_count), 32'd4);

        @(posedge clk); #1;
        out_ready = 1'b0; in_valid = 1'b1; in_op = 3'd2; in_data = 16'h1234;
        repeat (3) @(posedge clk);
        #1;
        in_valid = 1'b0; rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("midrst out_valid", 32'(out_valid), 32'd0);
        check("midrst xfer_count", 32'(xfer_count), 32'd0);
        check("midrst in_ready", 32'(in_ready), 32'd1);

        @(posedge clk); #1;
        b_in_valid = 1'b1; b_op = 3'd2; b_data = {8'h01, 8'h0F, 8'hFF};
        @(posedge clk); #1;
        b_op = 3'd0; b_data = {3{8'hFF}};
        @(posedge clk); #1;
        b_op = 3'd1; b_data = 24'h123456;
        @(negedge clk);
        check("nch3 xor valid", 32'(b_out_valid), 32'd1);
        check("nch3 xor data", 32'(b_out), 32'hF1);
        @(posedge clk); #1;
        b_data = 24'h000001;
        @(negedge clk);
        check("nch3 and data", 32'(b_out), 32'hFF);
        check("nch3 and all", 32'(b_all), 32'd1);
        check("nch3 count one", 32'(b_count), 32'd1);
        @(posedge clk); #1;
        b_data = 24'h800000;
        @(posedge clk); #1;
        b_in_valid = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        check("cnt2 saturate", 32'(b_count), 32'd3);

        took = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            @(posedge clk); #1;
            if (!in_valid || took) begin
                in_valid = ($urandom_range(0, 3) != 0);
                in_op    = 3'($urandom_range(0, 7));
                in_data  = 16'($urandom);
            end
            out_ready = ($urandom_range(0, 9) < 7);
            #1;
            took = in_valid && in_ready;
        end
        @(posedge clk); #1;
        in_valid = 1'b0; out_ready = 1'b1;
        repeat (5) @(posedge clk);
        @(negedge clk);
        check("drained", 32'(q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
